// File: rtl/piso_serializer.sv
// Parallel-in / serial-out frame serializer.
// A word is captured from par_in when the block is idle and load_valid is
// high, then shifted out one bit per enabled cycle (MSB-first or LSB-first,
// chosen at load time), followed by a single-cycle done pulse.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             leri,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load_fire;
  logic             shift_fire;
  logic             last_bit;

  // One shift step: dir=1 moves toward the MSB (MSB leaves first), dir=0
  // moves toward the LSB. The vacated end is always zero-filled.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] word,
                                                  input logic             dir);
    logic [WIDTH-1:0] res;
    if (dir) begin
      res = {word[WIDTH-2:0], 1'b0};
    end else begin
      res = {1'b0, word[WIDTH-1:1]};
    end
    return res;
  endfunction

  // The bit currently presented on the line depends only on stored state.
  function automatic logic head_bit(input logic [WIDTH-1:0] word,
                                    input logic             dir);
    return dir ? word[WIDTH-1] : word[0];
  endfunction

  assign load_fire  = (state_q == IDLE) && load_valid;
  assign shift_fire = (state_q == SHIFT) && ena;
  assign last_bit   = (cnt_q == CNT_LAST);

  // State register; reset drops straight back to IDLE, abandoning any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state outputs; data_out is driven from registers only.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    data_out   = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        data_out  = head_bit(shift_q, dir_q);
        if (ena && last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame datapath: capture on load, shift and count on each enabled bit.
  // The counter parks on its last value so it never wraps inside a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (load_fire) begin
      shift_q <= par_in;
      dir_q   <= leri;
      cnt_q   <= '0;
    end else if (shift_fire) begin
      shift_q <= shift_step(shift_q, dir_q);
      if (!last_bit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. A queue of pending frame bits
// serves as the reference: a load pushes WIDTH bits in transmit order,
// each enabled cycle pops one, and emptying the queue schedules done.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         leri;
  logic [W-1:0] par_in;
  logic         load_valid;
  logic         load_ready;
  logic         data_out;
  logic         out_valid;
  logic         done;

  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc_n  = 0;

  bit           exp_q[$];
  bit           m_done = 1'b0;

  logic [31:0]  cap;
  int           done_cnt  = 0;
  int           last_done = -1;
  int           done_gap  = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .leri       (leri),
    .par_in     (par_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference update for one rising edge, from the inputs held across it.
  task automatic model_edge();
    bit dn;
    bit dummy;
    dn = 1'b0;
    if (exp_q.size() > 0) begin
      if (ena) begin
        dummy = exp_q.pop_front();
        if (exp_q.size() == 0) dn = 1'b1;
      end
    end else if (!m_done && load_valid) begin
      for (int k = 0; k < W; k++) begin
        exp_q.push_back(leri ? par_in[W-1-k] : par_in[k]);
      end
    end
    m_done = dn;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_done = 1'b0;
  endtask

  task automatic check_out(input string tag);
    logic e_lr, e_ov, e_dn, e_d;
    e_ov = (exp_q.size() > 0);
    e_dn = m_done;
    e_lr = !e_ov && !e_dn;
    e_d  = e_ov ? exp_q[0] : 1'b0;
    chk({tag, ".load_ready"}, load_ready, e_lr);
    chk({tag, ".out_valid"},  out_valid,  e_ov);
    chk({tag, ".done"},       done,       e_dn);
    chk({tag, ".data_out"},   data_out,   e_d);
  endtask

  // Drive inputs at the falling edge, step the model at the rising edge,
  // then compare at the next falling edge.
  task automatic cyc(input logic e, input logic lv, input logic lr,
                     input logic [W-1:0] p, input string tag);
    ena        = e;
    load_valid = lv;
    leri       = lr;
    par_in     = p;
    @(posedge clk);
    model_edge();
    cyc_n++;
    @(negedge clk);
    check_out(tag);
    if (out_valid === 1'b1) cap = {cap[30:0], data_out};
    if (done === 1'b1) begin
      if (last_done >= 0) done_gap = cyc_n - last_done;
      last_done = cyc_n;
      done_cnt++;
    end
  endtask

  initial begin
    int d0;
    rst        = 1'b0;
    ena        = 1'b0;
    leri       = 1'b0;
    par_in     = '0;
    load_valid = 1'b0;
    cap        = '0;
    model_reset();
    #1;
    check_out("reset");

    // MSB-first frame, load on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    cap = '0;
    d0  = done_cnt;
    cyc(1'b1, 1'b1, 1'b1, 4'b1011, "msb_load");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 4'b0000, "msb");
    chk("msb_bits", cap[3:0], 32'b1011);
    chk("msb_done_cnt", done_cnt - d0, 1);

    // LSB-first frame
    cap = '0;
    d0  = done_cnt;
    cyc(1'b1, 1'b1, 1'b0, 4'b1011, "lsb_load");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 4'b0000, "lsb");
    chk("lsb_bits", cap[3:0], 32'b1101);
    chk("lsb_done_cnt", done_cnt - d0, 1);

    // ena gaps hold the current bit
    cap = '0;
    cyc(1'b1, 1'b1, 1'b1, 4'b1001, "hold_load");
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, "hold1");
    cyc(1'b0, 1'b0, 1'b1, 4'b0000, "hold0a");
    cyc(1'b0, 1'b0, 1'b1, 4'b0000, "hold0b");
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, "hold2");
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, "hold3");
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, "hold_done");
    chk("hold_bits", cap[5:0], 32'b100001);
    chk("hold_done", done, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, "hold_idle");

    // Input changes and load_valid during SHIFT and DONE are ignored
    cap = '0;
    d0  = done_cnt;
    cyc(1'b1, 1'b1, 1'b1, 4'b1011, "ign_load");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i[0], 4'b0110, "ign");
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, "ign_idle");
    chk("ign_bits", cap[3:0], 32'b1011);
    chk("ign_done_cnt", done_cnt - d0, 1);

    // Asynchronous reset after the 2nd bit aborts the frame
    d0 = done_cnt;
    cyc(1'b1, 1'b1, 1'b1, 4'b1011, "rst_load");
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, "rst_bit2");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_out("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_out("rst_held");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cap = '0;
    cyc(1'b1, 1'b1, 1'b0, 4'b0011, "post_rst_load");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'b0000, "post_rst");
    chk("rst_no_done", done_cnt - d0, 0);
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, "post_rst_done");
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, "post_rst_idle");
    chk("post_rst_bits", cap[3:0], 32'b1100);
    chk("post_rst_done_cnt", done_cnt - d0, 1);

    // Back-to-back frames with load_valid held high
    d0        = done_cnt;
    last_done = -1;
    done_gap  = 0;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), W'($urandom), "b2b");
    end
    chk("b2b_done_cnt", done_cnt - d0, 3);
    chk("b2b_spacing", done_gap, W + 2);
    load_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) cyc(1'b1, 1'b0, 1'b0, 4'b0000, "b2b_drain");

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), W'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
